// File: rtl/slow_gov_pkg.sv
// Shared types and constants for the slow-device governor.
package slow_gov_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } gov_state_e;

  localparam int unsigned DEFAULT_TICK_DIV = 4096;

endpackage

// File: rtl/slow_tick_div.sv
// Free-running prescaler producing a one-cycle registered Tick every TICK_DIV clocks.
module slow_tick_div
  import slow_gov_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
  parameter int unsigned TICK_W   = $clog2(TICK_DIV)
) (
  input  logic CLK,
  input  logic nPOR,
  output logic tick_o
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] presc_q, presc_d;
  logic              tick_q;

  always_comb presc_d = (presc_q == LAST) ? '0 : presc_q + TICK_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nPOR) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= (presc_q == LAST);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/slow_gov.sv
// Raises a registered slow-clock request on accesses to slow-enabled devices and
// holds it for SlowTimeout prescaled ticks after the bus goes idle.
module slow_gov
  import slow_gov_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
  parameter int unsigned TICK_W   = 12
) (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  output logic       SlowReq,
  output logic       SlowBusy,
  output logic [3:0] SlowCnt
);

  logic       tick;
  logic       bactr_q;
  logic       start;
  logic       match;
  logic [5:0] sel_hits;

  gov_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       req_q, busy_q;

  slow_tick_div #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_tick_div (
    .CLK    (CLK),
    .nPOR   (nPOR),
    .tick_o (tick)
  );

  // Selects only count on the first sampled cycle of a bus cycle.
  assign start    = BACT & ~bactr_q;
  assign sel_hits = {SndCS  & SlowSnd,
                     SCSICS & SlowSCSI,
                     SCCCS  & SlowSCC,
                     IWMCS  & SlowIWM,
                     VIACS  & SlowVIA,
                     IACKCS & SlowIACK};
  assign match    = start & (|sel_hits);

  always_comb begin
    // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (match) begin
      state_d = ACCESS;
      cnt_d   = SlowTimeout;
    end else begin
      case (state_q)
        IDLE:   state_d = IDLE;
        ACCESS: if (!BACT) state_d = HOLD;
        HOLD: begin
          if (tick) begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nPOR) begin
      bactr_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      bactr_q <= BACT;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      req_q   <= (state_d != IDLE) && SlowClockGate;
    end
  end

  assign SlowReq  = req_q;
  assign SlowBusy = busy_q;
  assign SlowCnt  = cnt_q;

endmodule
